// File: rtl/sitcp_tx_mux.sv
// N-channel round-robin word multiplexer feeding the SiTCP TCP TX byte port.
// Each word is sent MSB first, optionally preceded by a {tag, channel} header byte.
module sitcp_tx_mux #(
    parameter int         N_CH      = 4,
    parameter int         DATA_W    = 32,
    parameter bit         HEADER_EN = 1'b1,
    parameter logic [3:0] HDR_TAG   = 4'hA
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     TCP_OPEN,
    input  logic                     TCP_TX_FULL,
    output logic                     TCP_TX_WR,
    output logic [7:0]               TCP_TX_DATA,
    input  logic [N_CH-1:0]          CH_VALID,
    output logic [N_CH-1:0]          CH_READY,
    input  logic [N_CH*DATA_W-1:0]   CH_DATA,
    output logic                     BUSY,
    output logic [31:0]              WORD_CNT,
    output logic [15:0]              DROP_CNT
);

    localparam int NB    = DATA_W / 8;
    localparam int BI_W  = (NB > 1) ? $clog2(NB) : 1;
    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr, cur_ch, grant, idx;
    logic [BI_W-1:0]   bi;
    logic [DATA_W-1:0] shreg;
    logic              found, accept, emit, emit_hdr, last, abandon;
    logic [4:0]        n_valid;
    logic [16:0]       drop_sum;

    // Round-robin search starting just above the last granted channel.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = PTR_W'((int'(rr_ptr) + k) % N_CH);
            if (!found && CH_VALID[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    // While the connection is down every offered word is swallowed.
    always_comb begin
        CH_READY = '0;
        if (!RST) begin
            if (!TCP_OPEN)
                CH_READY = CH_VALID;
            else if (state_q == IDLE && found)
                CH_READY[grant] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        emit     = 1'b0;
        emit_hdr = 1'b0;
        last     = 1'b0;
        abandon  = 1'b0;
        case (state_q)
            IDLE: begin
                if (TCP_OPEN && found) begin
                    accept  = 1'b1;
                    state_d = HEADER_EN ? HDR : PAY;
                end
            end
            HDR: begin
                if (!TCP_OPEN) begin
                    abandon = 1'b1;
                    state_d = IDLE;
                end else if (!TCP_TX_FULL) begin
                    emit     = 1'b1;
                    emit_hdr = 1'b1;
                    state_d  = PAY;
                end
            end
            PAY: begin
                if (!TCP_OPEN) begin
                    abandon = 1'b1;
                    state_d = IDLE;
                end else if (!TCP_TX_FULL) begin
                    emit = 1'b1;
                    if (bi == BI_W'(NB - 1)) begin
                        last    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        n_valid = '0;
        for (int i = 0; i < N_CH; i++)
            n_valid = n_valid + 5'(CH_VALID[i]);
        drop_sum = 17'(DROP_CNT) + 17'(n_valid) + 17'(abandon);
    end

    assign BUSY = (state_q != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            rr_ptr      <= PTR_W'(N_CH - 1);
            cur_ch      <= '0;
            bi          <= '0;
            shreg       <= '0;
            TCP_TX_WR   <= 1'b0;
            TCP_TX_DATA <= '0;
            WORD_CNT    <= '0;
            DROP_CNT    <= '0;
        end else begin
            state_q   <= state_d;
            TCP_TX_WR <= emit;
            if (accept) begin
                shreg  <= CH_DATA[grant*DATA_W +: DATA_W];
                rr_ptr <= grant;
                cur_ch <= grant;
                bi     <= '0;
            end
            // Shift register always presents the next payload byte at its top.
            if (emit) begin
                if (emit_hdr) begin
                    TCP_TX_DATA <= {HDR_TAG, 4'(cur_ch)};
                end else begin
                    TCP_TX_DATA <= shreg[DATA_W-1 -: 8];
                    shreg       <= shreg << 8;
                    bi          <= bi + 1'b1;
                end
            end
            if (last)
                WORD_CNT <= WORD_CNT + 32'd1;
            if (!TCP_OPEN)
                DROP_CNT <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

endmodule

// File: tb/tb_sitcp_tx_mux.sv
// Bench for sitcp_tx_mux: byte scoreboard on the TX port plus directed corner sequences.
module tb_sitcp_tx_mux;

    logic         clk = 1'b0;
    always #4 clk = ~clk;

    logic         rst, open, full, tx_wr, busy;
    logic [7:0]   tx_data;
    logic [3:0]   ch_valid, ch_ready;
    logic [127:0] ch_data;
    logic [31:0]  word_cnt;
    logic [15:0]  drop_cnt;

    logic         rst8, open8, full8, wr8, busy8;
    logic [7:0]   d8;
    logic [3:0]   valid8, ready8;
    logic [31:0]  data8, wc8;
    logic [15:0]  dc8;

    sitcp_tx_mux #(.N_CH(4), .DATA_W(32), .HEADER_EN(1'b1), .HDR_TAG(4'hA)) dut (
        .CLK(clk), .RST(rst), .TCP_OPEN(open), .TCP_TX_FULL(full),
        .TCP_TX_WR(tx_wr), .TCP_TX_DATA(tx_data),
        .CH_VALID(ch_valid), .CH_READY(ch_ready), .CH_DATA(ch_data),
        .BUSY(busy), .WORD_CNT(word_cnt), .DROP_CNT(drop_cnt)
    );

    sitcp_tx_mux #(.N_CH(4), .DATA_W(8), .HEADER_EN(1'b0), .HDR_TAG(4'hA)) dut8 (
        .CLK(clk), .RST(rst8), .TCP_OPEN(open8), .TCP_TX_FULL(full8),
        .TCP_TX_WR(wr8), .TCP_TX_DATA(d8),
        .CH_VALID(valid8), .CH_READY(ready8), .CH_DATA(data8),
        .BUSY(busy8), .WORD_CNT(wc8), .DROP_CNT(dc8)
    );

    typedef struct {
        int          ch;
        logic [31:0] word;
        logic [7:0]  hdr;
        logic [31:0] cnt;
    } vec_t;

    vec_t        vt[4];
    logic [7:0]  exp_q[$];
    int          n_chk = 0, n_err = 0;
    int          cyc = 0, last_wr_cyc = 0, wr_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, need %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] hdr, input logic [31:0] w, input int nbytes);
        exp_q.push_back(hdr);
        for (int b = 0; b < nbytes; b++)
            exp_q.push_back(w[31-8*b -: 8]);
    endtask

    task automatic ticker();
        forever begin
            @(posedge clk);
            cyc++;
        end
    endtask

    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (tx_wr === 1'b1) begin
                wr_count++;
                last_wr_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_wr: byte %0h emitted, need no write", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_byte", 32'(tx_data), 32'(e));
                end
            end
        end
    endtask

    // Offer one word on one channel; ta is the cycle of the accepting edge.
    task automatic send(input int ch, input logic [31:0] w, input logic [7:0] hdr,
                        input int nbytes, output int ta);
        bit got;
        got = 1'b0;
        ta  = 0;
        ch_valid = 4'(1 << ch);
        ch_data[ch*32 +: 32] = w;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ch_ready[ch]) got = 1'b1;
            @(posedge clk); #1;
        end
        ch_valid = '0;
        if (got) begin
            ta = cyc;
            push_word(hdr, w, nbytes);
        end else begin
            n_chk++;
            n_err++;
            $display("FAIL accept_timeout: ch%0d ready stayed 0, need 1", ch);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++)
            @(posedge clk);
        @(posedge clk); #1;
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [31:0] rr_word(input int c);
        return 32'h10203040 + 32'(c) * 32'h01010101;
    endfunction

    initial begin
        int          ta, wr0;
        logic [31:0] wc0;
        logic [15:0] dc0;
        bit          got;

        vt[0] = '{ch: 0, word: 32'h11223344, hdr: 8'hA0, cnt: 32'd1};
        vt[1] = '{ch: 3, word: 32'hAABBCCDD, hdr: 8'hA3, cnt: 32'd2};
        vt[2] = '{ch: 1, word: 32'h00000000, hdr: 8'hA1, cnt: 32'd3};
        vt[3] = '{ch: 2, word: 32'hFFFFFFFF, hdr: 8'hA2, cnt: 32'd4};

        rst = 1'b1; open = 1'b1; full = 1'b0; ch_valid = '0; ch_data = '0;
        rst8 = 1'b1; open8 = 1'b1; full8 = 1'b0; valid8 = '0; data8 = '0;
        fork
            ticker();
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr", 32'(tx_wr), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_word_cnt", word_cnt, 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        rst = 1'b0; rst8 = 1'b0;

        // Single-word transfers: header + 4 bytes on consecutive cycles after accept.
        for (int v = 0; v < 4; v++) begin
            send(vt[v].ch, vt[v].word, vt[v].hdr, 4, ta);
            wait_drain();
            chk("latency", 32'(last_wr_cyc - ta), 32'd5);
            chk("word_cnt", word_cnt, vt[v].cnt);
        end

        // All channels valid: grants rotate 0,1,2,3,0 after reset.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) ch_data[c*32 +: 32] = rr_word(c);
        ch_valid = 4'hF;
        for (int w = 0; w < 5; w++) begin
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (|ch_ready) begin
                    got = 1'b1;
                    chk("rr_grant", 32'(ch_ready), 32'(1) << (w % 4));
                end
                @(posedge clk); #1;
            end
            if (got) push_word(8'hA0 | 8'(w % 4), rr_word(w % 4), 4);
            else begin
                n_chk++;
                n_err++;
                $display("FAIL rr_timeout: word %0d never granted, need grant", w);
            end
        end
        ch_valid = '0;
        wait_drain();
        chk("rr_word_cnt", word_cnt, 32'd5);

        // FULL held 3 cycles after the first payload byte.
        send(1, 32'hDEADBEEF, 8'hA1, 4, ta);
        @(posedge clk); #1;
        @(posedge clk); #1;
        full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_wr", 32'(tx_wr), 32'd0);
        end
        full = 1'b0;
        wait_drain();
        chk("stall_span", 32'(last_wr_cyc - ta), 32'd8);

        // Connection drops after two payload bytes.
        wc0 = word_cnt;
        dc0 = drop_cnt;
        send(2, 32'h01020304, 8'hA2, 2, ta);
        repeat (3) begin
            @(posedge clk); #1;
        end
        open = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_wr", 32'(tx_wr), 32'd0);
        chk("abort_drop", 32'(drop_cnt), 32'(dc0) + 32'd1);
        chk("abort_word_cnt", word_cnt, wc0);
        open = 1'b1;
        repeat (6) @(posedge clk);
        wait_drain();

        // Flush: 3 valid channels for 10 cycles while closed.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wr0 = wr_count;
        open = 1'b0;
        ch_valid = 4'b1011;
        #1;
        chk("flush_ready", 32'(ch_ready), 32'h0000000B);
        repeat (10) begin
            @(posedge clk); #1;
        end
        ch_valid = '0;
        open = 1'b1;
        chk("flush_drop", 32'(drop_cnt), 32'd30);
        chk("flush_no_wr", 32'(wr_count), 32'(wr0));

        // 8-bit, headerless instance: single byte per word, then reset mid-word.
        valid8 = 4'b0100;
        data8[16 +: 8] = 8'h5A;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ready8[2]) got = 1'b1;
            @(posedge clk); #1;
        end
        valid8 = '0;
        chk("b8_accept", 32'(got), 32'd1);
        chk("b8_wr_pre", 32'(wr8), 32'd0);
        @(posedge clk); #1;
        chk("b8_wr", 32'(wr8), 32'd1);
        chk("b8_data", 32'(d8), 32'h5A);
        chk("b8_word_cnt", wc8, 32'd1);
        @(posedge clk); #1;
        chk("b8_wr_post", 32'(wr8), 32'd0);
        chk("b8_idle", 32'(busy8), 32'd0);

        full8 = 1'b1;
        valid8 = 4'b0010;
        data8[8 +: 8] = 8'hC3;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ready8[1]) got = 1'b1;
            @(posedge clk); #1;
        end
        valid8 = '0;
        @(posedge clk); #1;
        chk("b8_held", 32'(busy8), 32'd1);
        rst8 = 1'b1;
        @(posedge clk); #1;
        chk("b8_rst_busy", 32'(busy8), 32'd0);
        chk("b8_rst_wr", 32'(wr8), 32'd0);
        chk("b8_rst_data", 32'(d8), 32'd0);
        chk("b8_rst_wc", wc8, 32'd0);
        rst8 = 1'b0;
        full8 = 1'b0;
        @(posedge clk); #1;
        chk("b8_discard", 32'(wr8), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
